// File: rtl/s_box_pkg.sv
// s_box_pkg: shared width constants and forward/inverse 5-bit substitution tables
package s_box_pkg;
  localparam int SBOX_W = 5;
  localparam int ROW_W = 1;
  localparam int COL_W = 4;
  localparam logic [SBOX_W-1:0] SBOX_FWD [0:31] = '{
    5'd4,  5'd11, 5'd31, 5'd20, 5'd26, 5'd21, 5'd9,  5'd2,
    5'd27, 5'd5,  5'd8,  5'd18, 5'd29, 5'd3,  5'd6,  5'd28,
    5'd30, 5'd19, 5'd7,  5'd14, 5'd0,  5'd13, 5'd17, 5'd24,
    5'd16, 5'd12, 5'd1,  5'd25, 5'd22, 5'd10, 5'd15, 5'd23
  };
  localparam logic [SBOX_W-1:0] SBOX_INV [0:31] = '{
    5'd20, 5'd26, 5'd7,  5'd13, 5'd0,  5'd9,  5'd14, 5'd18,
    5'd10, 5'd6,  5'd29, 5'd1,  5'd25, 5'd21, 5'd19, 5'd30,
    5'd24, 5'd22, 5'd11, 5'd17, 5'd3,  5'd5,  5'd28, 5'd31,
    5'd23, 5'd27, 5'd4,  5'd8,  5'd15, 5'd12, 5'd16, 5'd2
  };
endpackage

// File: rtl/s_box_lut.sv
// s_box_lut: combinational 5-bit table lookup, inverse select only with SBOX_INV_EN
module s_box_lut
  import s_box_pkg::*;
(
  input  logic [SBOX_W-1:0] idx,
`ifdef SBOX_INV_EN
  input  logic              inv,
`endif
  output logic [SBOX_W-1:0] val
);
  logic              row;
  logic [COL_W-1:0]  col;
  logic [SBOX_W-1:0] flat;
  assign {row, col} = idx;
  assign flat = {row, col};
`ifdef SBOX_INV_EN
  assign val = inv ? SBOX_INV[flat] : SBOX_FWD[flat];
`else
  assign val = SBOX_FWD[flat];
`endif
endmodule

// File: rtl/s_box_layer.sv
// s_box_layer: registered 5-bit S-box with 1-cycle latency and valid flag, inv port under SBOX_INV_EN
module s_box_layer
  import s_box_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [SBOX_W-1:0] x,
`ifdef SBOX_INV_EN
  input  logic              inv,
`endif
  output logic              out_valid,
  output logic [SBOX_W-1:0] Sx
);
  logic [SBOX_W-1:0] lut_val;
  s_box_lut u_lut (
    .idx (x),
`ifdef SBOX_INV_EN
    .inv (inv),
`endif
    .val (lut_val)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Sx        <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) Sx <= lut_val;
    end
  end
endmodule

// File: tb/tb_s_box_layer.sv
// tb_s_box_layer: directed scoreboard bench for s_box_layer
module tb_s_box_layer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b1;
  logic [4:0] x = 5'd7;
`ifdef SBOX_INV_EN
  logic       inv = 1'b0;
`endif
  logic       out_valid;
  logic [4:0] Sx;
  int         n_vec = 0;
  int         n_err = 0;
  logic [4:0] exp_q [$];
  logic [4:0] last_sx = 5'd0;
  logic [4:0] fwd_t [0:31] = '{4,11,31,20,26,21,9,2,27,5,8,18,29,3,6,28,
                               30,19,7,14,0,13,17,24,16,12,1,25,22,10,15,23};
`ifdef SBOX_INV_EN
  logic [4:0] inv_t [0:31] = '{20,26,7,13,0,9,14,18,10,6,29,1,25,21,19,30,
                               24,22,11,17,3,5,28,31,23,27,4,8,15,12,16,2};
`endif
  s_box_layer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .x         (x),
`ifdef SBOX_INV_EN
    .inv       (inv),
`endif
    .out_valid (out_valid),
    .Sx        (Sx)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [4:0] xx, input logic iv, input logic [4:0] e);
    logic [4:0] ex;
    in_valid = v;
    x = xx;
`ifdef SBOX_INV_EN
    inv = iv;
`endif
    @(posedge clk);
    if (v) exp_q.push_back(e);
    #1;
    chk("out_valid", {4'd0, out_valid}, {4'd0, v});
    if (v) begin
      ex = exp_q.pop_front();
      last_sx = ex;
      chk(iv ? "sx_inv" : "sx_fwd", Sx, ex);
    end else chk("sx_hold", Sx, last_sx);
  endtask
  initial begin
    logic [4:0] outs [0:31];
    bit         seen [0:31];
    int         distinct;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_sx", Sx, 5'd0);
      chk("rst_valid", {4'd0, out_valid}, 5'd0);
    end
    rst_n = 1'b1;
    drive(1'b1, 5'd7, 1'b0, 5'd2);
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 5'(i), 1'b0, fwd_t[i]);
      outs[i] = Sx;
    end
    for (int i = 0; i < 32; i++) seen[i] = 1'b0;
    for (int i = 0; i < 32; i++) seen[outs[i]] = 1'b1;
    distinct = 0;
    for (int i = 0; i < 32; i++) distinct += int'(seen[i]);
    chk("distinct", 5'(distinct - 1), 5'd31);
    drive(1'b1, 5'd2, 1'b0, 5'd31);
    drive(1'b0, 5'd3, 1'b0, 5'd0);
    drive(1'b0, 5'd3, 1'b0, 5'd0);
    drive(1'b1, 5'd9, 1'b0, 5'd5);
    in_valid = 1'b1;
    x = 5'd10;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_sx", Sx, 5'd0);
    chk("async_rst_valid", {4'd0, out_valid}, 5'd0);
    #1 rst_n = 1'b1;
    last_sx = 5'd0;
    drive(1'b0, 5'd10, 1'b0, 5'd0);
    drive(1'b1, 5'd5, 1'b0, 5'd21);
`ifdef SBOX_INV_EN
    for (int i = 0; i < 32; i++) drive(1'b1, 5'(i), 1'b1, inv_t[i]);
    for (int i = 0; i < 32; i++) drive(1'b1, fwd_t[i], 1'b1, 5'(i));
    drive(1'b1, 5'd31, 1'b0, 5'd23);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/s_box_layer.md
# s_box_layer

Registered 5-bit substitution box for the cipher datapath's nonlinear layer. The 5-bit input is split into a 1-bit row (x[4]) and a 4-bit column (x[3:0]) and mapped through a fixed bijective 2×16 table to a 5-bit output. The result appears one clock later with a valid flag. The block sits between the key-mix stage and the linear diffusion layer.

## Interface
- No parameters; the width is fixed at 5 bits.
- clk  input  1  rising-edge clock, the single clock domain
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  x is sampled on this clock edge
- x  input  5  input word; row = x[4], column = x[3:0]
- inv  input  1  selects the inverse table; this port exists only with SBOX_INV_EN
- out_valid  output  1  Sx holds a new result
- Sx  output  5  substituted word

## Operation
- Forward table, flat index = x = row·16 + column, giving Sx in decimal:
  - Row 0, columns 0–15: 4,11,31,20,26,21,9,2,27,5,8,18,29,3,6,28
  - Row 1, columns 0–15: 30,19,7,14,0,13,17,24,16,12,1,25,22,10,15,23
- Inverse table, used when SBOX_INV_EN is defined and inv=1, indexed 0–31:
  - 20,26,7,13,0,9,14,18,10,6,29,1,25,21,19,30,24,22,11,17,3,5,28,31,23,27,4,8,15,12,16,2
- The inverse satisfies inv(fwd(v)) = v for all 32 values of v.
- The lookup is purely combinational. Its result is captured into the Sx register when in_valid=1.
- When in_valid=0, Sx holds its previous value.
- There is no back-pressure; a new input is accepted every cycle.
- X or Z on x is not sanitised. Behaviour on x is defined only for known inputs.

## Timing
- Latency is 1 cycle: x sampled at edge N appears on Sx after edge N, with out_valid=1.
- out_valid is a registered copy of in_valid.
- While rst_n=0, asynchronously and immediately: Sx=5'b00000 and out_valid=0. Sx=0 at reset is a reset value only, not a table result.
- Reset asserted mid-stream discards the in-flight result. The first valid output after release comes from the first in_valid=1 sampled after rst_n rises.
- Back-to-back in_valid gives one result per cycle with no bubbles.
- The inv input is sampled on the same edge as x.

## Configuration
- SBOX_INV_EN defined:
  - The inv port exists.
  - inv=1 selects the inverse table; inv=0 selects the forward table.
- SBOX_INV_EN undefined:
  - There is no inv port and no inverse table logic.
  - The forward table is always used.

## Structure
- Shared package s_box_pkg contains:
  - the width constant SBOX_W = 5
  - the row width (1) and column width (4)
  - the forward table constant SBOX_FWD[0:31]
  - the inverse table constant SBOX_INV[0:31]
- Sub-module s_box_lut: a combinational lookup taking a 5-bit index and an inv select and returning a 5-bit value.
- The top level holds only the registers, the valid pipeline and the reset logic.

## Test plan
- Reset: hold rst_n=0 while driving in_valid=1, x=5'd7 → Sx=0 and out_valid=0 throughout. After release, the first edge with in_valid=1 gives out_valid=1 one cycle later.
- Exhaustive forward sweep: x = 0..31 with in_valid=1 on consecutive edges, inv=0.
  - Each Sx matches the forward table one cycle later, e.g. x=0→4, x=15→28, x=16→30, x=31→23.
  - The 32 outputs are all distinct.
- Hold: after in_valid=1 with x=5'd2 (Sx=31), drive in_valid=0 and x=5'd3 → Sx stays 31 and out_valid=0.
- Mid-stream reset: drive x=5'd10 with in_valid=1, then pulse rst_n low between edges → Sx=0 and out_valid=0 immediately, asynchronously.
- With SBOX_INV_EN, inverse sweep: inv=1, x = 0..31 → Sx matches the inverse table, e.g. x=4→0, x=31→2.
- With SBOX_INV_EN, round trip: feed each forward output back with inv=1 → the original x is recovered for all 32 values.
